// File: rtl/pad_mux_pkg.sv
// pad_mux_pkg: register word offsets, PADCFG bit layout, reset value and decode helper shared by pad_mux_ctrl
package pad_mux_pkg;
  localparam int GPO_OFS = 0;
  localparam int GPOE_OFS = 1;
  localparam int GPI_OFS = 2;
  localparam int IRQ_EN_OFS = 3;
  localparam int IRQ_PEND_OFS = 4;
  localparam int IE_BIT = 8;
  localparam int CS_BIT = 9;
  localparam int SL_BIT = 10;
  localparam int PU_BIT = 11;
  localparam int PD_BIT = 12;
  typedef struct packed {
    logic pd;
    logic pu;
    logic sl;
    logic cs;
    logic ie;
    logic [7:0] fsel;
  } padcfg_t;
  localparam padcfg_t PADCFG_RST = 13'h0500;
  function automatic padcfg_t to_padcfg(input logic [12:0] d, input logic [7:0] fsel_mask);
    padcfg_t c;
    c.pd = d[PD_BIT];
    c.pu = d[PU_BIT];
    c.sl = d[SL_BIT];
    c.cs = d[CS_BIT];
    c.ie = d[IE_BIT];
    c.fsel = d[7:0] & fsel_mask;
    return c;
  endfunction
endpackage

// File: rtl/pad_mux_sync.sv
// pad_mux_sync: STAGES-flop input synchroniser with rising-edge detect; clk_i/rst_i, d_i raw in, sync_o synchronised, rise_o one-cycle rising pulse
module pad_mux_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/pad_mux_ctrl.sv
// pad_mux_ctrl: Wishbone-configured pad function mux with break-before-make blanking, GPIO, input sync and edge IRQ; ports: wb_* slave, fn_out_i/fn_oe_i function sources, pad_in_i raw, pad_* controls, irq_o
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int NUM_PADS = 16,
  parameter int NUM_FUNCS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int BBM_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [4:0]                    wb_adr_i,
  input  logic [31:0]                   wb_dat_i,
  output logic [31:0]                   wb_dat_o,
  output logic                          wb_ack_o,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] fn_out_i,
  input  logic [NUM_FUNCS*NUM_PADS-1:0] fn_oe_i,
  input  logic [NUM_PADS-1:0]           pad_in_i,
  output logic [NUM_PADS-1:0]           pad_in_sync_o,
  output logic [NUM_PADS-1:0]           pad_out_o,
  output logic [NUM_PADS-1:0]           pad_oe_o,
  output logic [NUM_PADS-1:0]           pad_ie_o,
  output logic [NUM_PADS-1:0]           pad_cs_o,
  output logic [NUM_PADS-1:0]           pad_sl_o,
  output logic [NUM_PADS-1:0]           pad_pu_o,
  output logic [NUM_PADS-1:0]           pad_pd_o,
  output logic                          irq_o
);
  localparam int FW = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
  localparam int CW = $clog2(BBM_CYCLES + 1);
  localparam logic [7:0] FSEL_MASK = 8'((1 << FW) - 1);
  localparam logic [CW-1:0] BBM_LOAD = CW'(BBM_CYCLES);
  padcfg_t [NUM_PADS-1:0] cfg_q, cfg_d;
  logic [NUM_PADS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_PADS-1:0] gpo_q, gpo_d, gpoe_q, gpoe_d, irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  logic [NUM_PADS-1:0] pad_out_q, pad_out_d, pad_oe_q, pad_oe_d, rise, wmask;
  logic [NUM_FUNCS-1:0][NUM_PADS-1:0] fn_out_m, fn_oe_m;
  logic ack_q, ack_d, irq_q, irq_d, acc, wr, unused_ok;
  logic [31:0] dat_q, dat_d, adr, rdata;
  logic [FW-1:0] fs;
  padcfg_t wcfg;
  assign fn_out_m = fn_out_i;
  assign fn_oe_m = fn_oe_i;
  assign unused_ok = ^wb_dat_i;
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_sync
    pad_mux_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (pad_in_i[i]),
      .sync_o(pad_in_sync_o[i]),
      .rise_o(rise[i])
    );
  end
  always_comb begin
    adr = 32'(wb_adr_i);
    acc = wb_cyc_i & wb_stb_i & ~ack_q;
    wr = acc & wb_we_i;
    wcfg = to_padcfg(wb_dat_i[12:0], FSEL_MASK);
    wmask = wb_dat_i[NUM_PADS-1:0];
    gpo_d = (wr && adr == NUM_PADS + GPO_OFS) ? wmask : gpo_q;
    gpoe_d = (wr && adr == NUM_PADS + GPOE_OFS) ? wmask : gpoe_q;
    irq_en_d = (wr && adr == NUM_PADS + IRQ_EN_OFS) ? wmask : irq_en_q;
    // set term is OR-ed after the clear so a coincident edge survives W1C
    irq_pend_d = (irq_pend_q & ~((wr && adr == NUM_PADS + IRQ_PEND_OFS) ? wmask : '0)) | (rise & irq_en_q);
    irq_d = |(irq_pend_q & irq_en_q);
    rdata = (adr == NUM_PADS + GPO_OFS) ? 32'(gpo_q) :
            (adr == NUM_PADS + GPOE_OFS) ? 32'(gpoe_q) :
            (adr == NUM_PADS + GPI_OFS) ? 32'(pad_in_sync_o) :
            (adr == NUM_PADS + IRQ_EN_OFS) ? 32'(irq_en_q) :
            (adr == NUM_PADS + IRQ_PEND_OFS) ? 32'(irq_pend_q) : '0;
    cfg_d = cfg_q;
    fs = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (wr && adr == p) cfg_d[p] = wcfg;
      if (adr == p) rdata = 32'(cfg_q[p]);
      cnt_d[p] = (wr && adr == p && wcfg.fsel != cfg_q[p].fsel) ? BBM_LOAD :
                 (cnt_q[p] != '0) ? cnt_q[p] - CW'(1) : '0;
      // blank on the next count so the pad is quiet from the write edge itself
      fs = cfg_q[p].fsel[FW-1:0];
      pad_out_d[p] = (cnt_d[p] != '0 || 32'(fs) >= NUM_FUNCS) ? 1'b0 : (fs == '0) ? gpo_q[p] : fn_out_m[fs][p];
      pad_oe_d[p] = (cnt_d[p] != '0 || 32'(fs) >= NUM_FUNCS) ? 1'b0 : (fs == '0) ? gpoe_q[p] : fn_oe_m[fs][p];
      pad_ie_o[p] = cfg_q[p].ie;
      pad_cs_o[p] = cfg_q[p].cs;
      pad_sl_o[p] = cfg_q[p].sl;
      pad_pu_o[p] = cfg_q[p].pu;
      pad_pd_o[p] = cfg_q[p].pd;
    end
    ack_d = acc;
    dat_d = acc ? rdata : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q <= {NUM_PADS{PADCFG_RST}};
      cnt_q <= '0;
      gpo_q <= '0;
      gpoe_q <= '0;
      irq_en_q <= '0;
      irq_pend_q <= '0;
      pad_out_q <= '0;
      pad_oe_q <= '0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
      dat_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      gpo_q <= gpo_d;
      gpoe_q <= gpoe_d;
      irq_en_q <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      pad_out_q <= pad_out_d;
      pad_oe_q <= pad_oe_d;
      ack_q <= ack_d;
      irq_q <= irq_d;
      dat_q <= dat_d;
    end
  end
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign pad_out_o = pad_out_q;
  assign pad_oe_o = pad_oe_q;
  assign irq_o = irq_q;
endmodule

// File: doc/pad_mux_ctrl.md
PAD_MUX_CTRL -- requirements
Module: pad_mux_ctrl

Interface
REQ-001 SHALL have parameter NUM_PADS, default 16, number of muxed bidir pads (legal range 1..27).
REQ-002 SHALL have parameter NUM_FUNCS, default 4, number of pad functions; function 0 is GPIO. FW = max(1, clog2(NUM_FUNCS)).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (minimum 2).
REQ-004 SHALL have parameter BBM_CYCLES, default 4, break-before-make blanking length (minimum 1).
REQ-005 SHALL have ports, one per line:
- clk_i  in  1  clock, the only clock.
- rst_i  in  1  reset; asynchronous, active-high.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave controls.
- wb_adr_i  in  5  word address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- fn_out_i  in  NUM_FUNCS*NUM_PADS  per-function output data; function f, pad p at bit f*NUM_PADS+p.
- fn_oe_i  in  NUM_FUNCS*NUM_PADS  per-function output enables, same packing.
- pad_in_i  in  NUM_PADS  raw pad input.
- pad_in_sync_o  out  NUM_PADS  synchronised pad input.
- pad_out_o, pad_oe_o, pad_ie_o, pad_cs_o, pad_sl_o, pad_pu_o, pad_pd_o  out  NUM_PADS each  pad controls.
- irq_o  out  1  level interrupt.

Function
REQ-006 SHALL map words 0..NUM_PADS-1 to PADCFG[p]: bits [FW-1:0] FSEL, bit 8 IE, 9 CS, 10 SL, 11 PU, 12 PD. Other bits SHALL read 0.
REQ-007 SHALL map word NUM_PADS to GPO, NUM_PADS+1 to GPOE, NUM_PADS+2 to GPI (read-only, equals pad_in_sync_o), NUM_PADS+3 to IRQ_EN, NUM_PADS+4 to IRQ_PEND (write-1-to-clear).
REQ-008 SHALL assert wb_ack_o for exactly one cycle, in the cycle after cyc&stb is first seen. SHALL hold it low for one cycle after each ack, so back-to-back accesses get an ack every second cycle.
REQ-009 SHALL update registers on the clock edge that asserts wb_ack_o. wb_dat_o SHALL be valid while wb_ack_o is high and 0 otherwise.
REQ-010 SHALL acknowledge unmapped addresses: writes are ignored, reads return 0.
REQ-011 SHALL register pad_out_o and pad_oe_o. Each SHALL equal the selected source one cycle after the input changes: fn_out_i/fn_oe_i for FSEL≠0, GPO/GPOE for FSEL=0.
REQ-012 SHALL treat FSEL ≥ NUM_FUNCS as output disabled: pad_oe_o=0, pad_out_o=0.
REQ-013 SHALL drive pad_ie_o, pad_cs_o, pad_sl_o, pad_pu_o, pad_pd_o directly from the PADCFG flops, effective the cycle after the write.
REQ-014 SHALL start a per-pad blanking counter at BBM_CYCLES when FSEL is written with a value different from the current one.
REQ-015 While the counter ≠ 0, SHALL force pad_oe_o=0 and pad_out_o=0. The new function SHALL drive the pad in the cycle after the counter reaches 0.
REQ-016 A write of an identical FSEL SHALL NOT blank the pad. A new differing FSEL written during blanking SHALL restart the counter at BBM_CYCLES.
REQ-017 SHALL pass pad_in_i through an SYNC_STAGES-flop synchroniser. Inputs SHALL be synchronised regardless of IE.
REQ-018 A rising edge of pad_in_sync_o[p] with IRQ_EN[p]=1 SHALL set IRQ_PEND[p] one cycle later.
REQ-019 If a set and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-020 irq_o SHALL be registered and equal |(IRQ_PEND & IRQ_EN).

Reset
REQ-021 On rst_i SHALL asynchronously set, per pad: FSEL=0, IE=1, CS=0, SL=1, PU=0, PD=0.
REQ-022 On rst_i SHALL asynchronously clear GPO, GPOE, IRQ_EN, IRQ_PEND, blanking counters and synchroniser flops.
REQ-023 On rst_i SHALL drive outputs as follows: pad_oe_o=0, pad_out_o=0, wb_ack_o=0, wb_dat_o=0, irq_o=0, pad_ie_o=1, pad_sl_o=1, all other pad controls 0.
REQ-024 Reset asserted mid-transaction or mid-blanking SHALL abort it; no ack SHALL follow deassertion.

Structure
REQ-025 SHALL place the following in package pad_mux_pkg: register word offsets, PADCFG bit positions, the PADCFG reset value, and a packed PADCFG struct typedef.
REQ-026 SHALL instantiate sub-module pad_mux_sync once per pad; it contains the synchroniser and rising-edge detector.

Verification
REQ-027 Reset release -> all pad_oe_o=0, pad_ie_o=all-ones, read PADCFG[0] returns 0x0500.
REQ-028 Write GPOE=0x1, GPO=0x1 -> pad_oe_o[0]=1 and pad_out_o[0]=1 one cycle after the second ack; read GPO returns 0x1.
REQ-029 Write PADCFG[3].FSEL=2 with fn_oe_i asserted for function 2 -> pad_oe_o[3]=0 for 4 cycles, then follows fn_oe_i; rewrite FSEL=2 -> no blanking.
REQ-030 Write FSEL=1 then FSEL=2 two cycles later -> blanking totals 6 cycles from the first write.
REQ-031 IRQ_EN=0x4, pulse pad_in_i[2] -> irq_o high 4 cycles after the edge; W1C in the same cycle as a new edge -> IRQ_PEND[2] stays 1.
REQ-032 Read word 31 -> ack, data 0; assert rst_i during a pending access -> no ack.
